tpg_multi_pattern: RTL
======================

// Module: tpg_multi_pattern
// PURPOSE
//  Programmable video timing + test-pattern generator; successor of the fixed-ramp TPG.
//  Produces hs/vs/vld raster timing from run-time registers and one of four patterns
//  (ramp, colour bars, checker, solid). Sits at the head of the video pipe as the
//  pixel source for downstream scaler/packer blocks and for bring-up.
// PARAMETERS
//  PW        8   bits per colour component
//  H_BITS    12  horizontal counter / timing width
//  V_BITS    12  vertical counter / timing width
//  BAR_SHIFT 4   colour-bar width = 2**BAR_SHIFT pixels
//  CHK_SHIFT 3   checker square = 2**CHK_SHIFT pixels
//  FC_BITS   16  frame counter width
// PORTS
//  clk          in   1       clock
//  rst_n        in   1       synchronous reset, active low
//  en           in   1       run enable
//  mode         in   2       0 ramp, 1 colour bars, 2 checker, 3 solid
//  solid_rgb    in   3*PW    colour for mode 3, {R,G,B}
//  tHS_START/tHS_END/tHACT_START/tHACT_END/tH_END  in  H_BITS  horizontal timing
//  tVS_START/tVS_END/tVACT_START/tVACT_END/tV_END  in  V_BITS  vertical timing
//  hs, vs, vld  out  1       sync and data-valid
//  sof          out  1       pulse with first vld pixel of frame
//  eol          out  1       pulse with last vld pixel of each line
//  rgb          out  3*PW    pixel {R,G,B}
//  frame_cnt    out  FC_BITS completed frames, wraps
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): x=y=0, all outputs 0, shadow regs cleared.
//  - en=0: counters held at x=y=0, all outputs 0 next cycle; frame_cnt holds.
//    en 0->1 starts a fresh frame at x=y=0.
//  - x counts 0..tH_END inclusive, wraps to 0; y increments on x wrap, 0..tV_END, wraps.
//    y wrap increments frame_cnt (modulo 2**FC_BITS).
//  - Timing inputs and mode/solid_rgb latched into shadow regs when (x,y)=(0,0) and en=1;
//    mid-frame input changes have no effect until next frame.
//  - hs=1 iff tHS_START<=x<tHS_END; vs=1 iff tVS_START<=y<tVS_END (half-open).
//  - vld=1 iff tHACT_START<=x<tHACT_END and tVACT_START<=y<tVACT_END.
//    START>=END on any axis -> that signal never asserts; no other side effect.
//  - Latency: all outputs registered; counter state (x,y) at cycle n -> outputs at n+1.
//  - xa = x-tHACT_START, ya = y-tVACT_START, truncated modulo; rgb=0 whenever vld=0.
//  - mode 0: rgb={xa[PW-1:0]} replicated x3 (wraps each 2**PW px).
//  - mode 1: i=xa[BAR_SHIFT+2:BAR_SHIFT]; R=~i[1], G=~i[2], B=~i[0], each bit
//    expanded to all-ones/zero: white,yellow,cyan,green,magenta,red,blue,black, repeats.
//  - mode 2: xa[CHK_SHIFT]^ya[CHK_SHIFT] -> all-ones else all-zeros.
//  - mode 3: rgb=shadowed solid_rgb.
//  - sof = vld on first active pixel of first active line; eol = vld with x==tHACT_END-1.
//  - Timing values beyond tH_END/tV_END simply never match; counters never exceed END.
// CONFIGURATION
//  TPG_MOTION_EN defined: xa replaced by xa+frame_cnt[H_BITS-1:0] (modes 0-2),
//    pattern scrolls left one pixel per frame.
//  Undefined: pattern static; frame_cnt still counts.
// TESTING
//  tH_END=15,tV_END=9,tHACT 2..14,tVACT 1..9, mode0 -> 12 vld px/line, rgb 0..11, 8 lines/frame.
//  Same timing, 3 frames -> frame_cnt 0->3, exactly one sof per frame, 8 eol per frame.
//  mode1, BAR_SHIFT=1, tHACT 0..16 -> bars 2px each: FFFFFF,FFFF00,00FFFF,00FF00,FF00FF,FF0000,0000FF,000000.
//  Change mode 0->3 (solid_rgb=123456) mid-frame -> no change until next (0,0); then rgb=123456.
//  en dropped mid-line, rst_n=0 mid-frame -> all outputs 0 next cycle; restart at x=y=0.
//  TPG_MOTION_EN, mode0 -> first pixel rgb of frame k equals k (mod 2**PW).

Source files
------------

// File: rtl/tpg_multi_pattern.sv
// Programmable raster timing + test-pattern generator (ramp, colour bars, checker, solid).
// Optional build macro TPG_MOTION_EN: scrolls modes 0-2 left one pixel per completed frame.
module tpg_multi_pattern #(
  parameter int PW        = 8,
  parameter int H_BITS    = 12,
  parameter int V_BITS    = 12,
  parameter int BAR_SHIFT = 4,
  parameter int CHK_SHIFT = 3,
  parameter int FC_BITS   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [3*PW-1:0]   solid_rgb,
  input  logic [H_BITS-1:0] tHS_START,
  input  logic [H_BITS-1:0] tHS_END,
  input  logic [H_BITS-1:0] tHACT_START,
  input  logic [H_BITS-1:0] tHACT_END,
  input  logic [H_BITS-1:0] tH_END,
  input  logic [V_BITS-1:0] tVS_START,
  input  logic [V_BITS-1:0] tVS_END,
  input  logic [V_BITS-1:0] tVACT_START,
  input  logic [V_BITS-1:0] tVACT_END,
  input  logic [V_BITS-1:0] tV_END,
  output logic              hs,
  output logic              vs,
  output logic              vld,
  output logic              sof,
  output logic              eol,
  output logic [3*PW-1:0]   rgb,
  output logic [FC_BITS-1:0] frame_cnt
);

  typedef struct packed {
    logic [H_BITS-1:0] hsS, hsE, haS, haE, hEnd;
    logic [V_BITS-1:0] vsS, vsE, vaS, vaE, vEnd;
    logic [1:0]        mode;
    logic [3*PW-1:0]   solid;
  } cfg_t;

  cfg_t              shadow, liveCfg, cfg;
  logic [H_BITS-1:0] x, xa;
  logic [V_BITS-1:0] y, ya;
  logic              atOrigin, hAct, vAct, vldN, xWrap, yWrap;
  logic [2:0]        barIdx;
  logic [3*PW-1:0]   pat;

  // The first pixel of a frame already uses the freshly presented settings,
  // so a frame is always rendered with one consistent configuration.
  always_comb begin
    liveCfg       = '0;
    liveCfg.hsS   = tHS_START;
    liveCfg.hsE   = tHS_END;
    liveCfg.haS   = tHACT_START;
    liveCfg.haE   = tHACT_END;
    liveCfg.hEnd  = tH_END;
    liveCfg.vsS   = tVS_START;
    liveCfg.vsE   = tVS_END;
    liveCfg.vaS   = tVACT_START;
    liveCfg.vaE   = tVACT_END;
    liveCfg.vEnd  = tV_END;
    liveCfg.mode  = mode;
    liveCfg.solid = solid_rgb;
    atOrigin      = (x == '0) && (y == '0);
    cfg           = atOrigin ? liveCfg : shadow;
  end

  always_comb begin
    hAct  = (x >= cfg.haS) && (x < cfg.haE);
    vAct  = (y >= cfg.vaS) && (y < cfg.vaE);
    vldN  = hAct && vAct;
    xWrap = (x >= cfg.hEnd);
    yWrap = (y >= cfg.vEnd);
`ifdef TPG_MOTION_EN
    xa    = x - cfg.haS + H_BITS'(frame_cnt);
`else
    xa    = x - cfg.haS;
`endif
    ya     = y - cfg.vaS;
    barIdx = xa[BAR_SHIFT+2:BAR_SHIFT];
    pat    = '0;
    case (cfg.mode)
      2'd0: pat = {3{xa[PW-1:0]}};
      2'd1: pat = {{PW{~barIdx[1]}}, {PW{~barIdx[2]}}, {PW{~barIdx[0]}}};
      2'd2: pat = {3*PW{xa[CHK_SHIFT] ^ ya[CHK_SHIFT]}};
      default: pat = cfg.solid;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x <= '0; y <= '0; shadow <= '0; frame_cnt <= '0;
      hs <= 1'b0; vs <= 1'b0; vld <= 1'b0; sof <= 1'b0; eol <= 1'b0; rgb <= '0;
    end else if (!en) begin
      x <= '0; y <= '0;
      hs <= 1'b0; vs <= 1'b0; vld <= 1'b0; sof <= 1'b0; eol <= 1'b0; rgb <= '0;
    end else begin
      shadow <= cfg;
      x      <= xWrap ? '0 : x + 1'b1;
      if (xWrap) begin
        y <= yWrap ? '0 : y + 1'b1;
        if (yWrap) frame_cnt <= frame_cnt + 1'b1;
      end
      hs  <= (x >= cfg.hsS) && (x < cfg.hsE);
      vs  <= (y >= cfg.vsS) && (y < cfg.vsE);
      vld <= vldN;
      sof <= vldN && (x == cfg.haS) && (y == cfg.vaS);
      eol <= vldN && (x == cfg.haE - 1'b1);
      rgb <= vldN ? pat : '0;
    end
  end

endmodule
